frame_parser: RTL and testbench
===============================

// Module: frame_parser
// PURPOSE
//   Byte-stream command-frame parser between the UART receiver and the command dispatcher.
//   Frame format: AA 55 CMD LEN_H LEN_L PAYLOAD[LEN] CHK.
//   CHK = (CMD + LEN_H + LEN_L + sum(PAYLOAD)) mod 256.
//   Streams payload bytes downstream, then reports exactly one result per frame: done, or error with a code.
// PARAMETERS
//   MAX_PAYLOAD_LEN  256     largest legal LEN; LEN > this is rejected
//   TIMEOUT_CLKS     50000   max clk cycles between bytes inside a frame before abort
// PORTS
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous active-low reset
//   rx_data        in   8   byte from UART receiver
//   rx_valid       in   1   one-cycle strobe: rx_data valid
//   cmd_out        out  8   CMD of current/last frame
//   len_out        out  16  LEN of current/last frame
//   payload_data   out  8   payload byte
//   payload_valid  out  1   one-cycle strobe per payload byte
//   frame_start    out  1   one-cycle pulse when CMD byte accepted
//   frame_done     out  1   one-cycle pulse: checksum matched
//   frame_error    out  1   one-cycle pulse: frame aborted
//   error_code     out  2   01 checksum, 10 length, 11 timeout; held until next error
// BEHAVIOUR
// - Reset: state=IDLE; all outputs, checksum acc, payload counter, timeout counter = 0.
//   Asserting rst_n low mid-frame discards the frame with no done/error pulse.
// - All outputs registered; every response appears 1 clk after the rx_valid cycle causing it.
// - State machine, advancing only on rx_valid:
//   - IDLE: AA -> SYNC; else stay.
//   - SYNC: 55 -> CMD; AA -> stay SYNC; else -> IDLE.
//   - CMD: latch cmd_out, acc=byte, pulse frame_start -> LEN_H.
//   - LEN_H: latch len_out[15:8], acc+=byte -> LEN_L.
//   - LEN_L: latch len_out[7:0], acc+=byte.
//     - LEN > MAX_PAYLOAD_LEN: frame_error, code 10 -> IDLE.
//     - LEN == 0: -> CHK.
//     - Otherwise: cnt=LEN -> PAYLOAD.
//   - PAYLOAD: payload_data=byte, payload_valid=1, acc+=byte, cnt-=1; cnt reaching 0 -> CHK.
//   - CHK: byte==acc -> frame_done; else frame_error, code 01. -> IDLE.
// - acc is 8 bit, wraps mod 256. Header bytes AA/55 are excluded from the sum.
// - Length check uses the full 16-bit value; LEN == MAX_PAYLOAD_LEN is legal.
// - No resync inside CMD..CHK: AA/55 bytes there are plain data.
// - Timeout counter:
//   - Runs in every state except IDLE and SYNC; clears on each rx_valid.
//   - Reaching TIMEOUT_CLKS gives frame_error, code 11 -> IDLE.
//   - SYNC gets no timeout; it waits indefinitely.
//   - If expiry coincides with rx_valid, the byte wins and there is no timeout.
// - cmd_out/len_out are updated as their bytes arrive and hold until the next frame overwrites them.
// - Consumers must treat streamed payload as tentative until frame_done; on frame_error they discard it.
// - frame_done and frame_error are never high in the same cycle; at most one pulses per frame_start.
// - No backpressure: the parser accepts rx_valid on any cycle, including back-to-back cycles.
// TESTING
//   1. AA 55 FF 00 00 FF -> frame_start; cmd_out=FF, len_out=0000; no payload_valid; frame_done x1.
//   2. AA 55 01 00 04 DE AD BE EF 3D -> payload_valid x4 carrying DE,AD,BE,EF in order; frame_done.
//   3. Same frame with CHK=3C -> 4 payload strobes, then frame_error with code 01; no frame_done.
//   4. AA 55 02 01 01 04 -> frame_error code 10 after LEN_L; trailing 04 ignored in IDLE.
//      Next valid frame still parses OK.
//   5. AA 55 01 00 04 DE, then silence > TIMEOUT_CLKS -> frame_error code 11 -> IDLE.
//      Stray bytes 00 AA AA 55 FF 00 00 FF -> resyncs and gives frame_done.
//   6. rst_n low during PAYLOAD of frame 2 -> no done/error pulse, outputs 0.
//      After release, frame 1 -> frame_done.
//      Also drive rx_valid back-to-back (1 clk apart) for frame 2 -> frame_done.

Source files
------------

// File: rtl/frame_parser_if.sv
// rtl/frame_parser_if.sv - byte-in / frame-out signal bundle for frame_parser
interface frame_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  cmd_out;
    logic [15:0] len_out;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        frame_start;
    logic        frame_done;
    logic        frame_error;
    logic [1:0]  error_code;

    modport master (
        output rx_data, rx_valid,
        input  cmd_out, len_out, payload_data, payload_valid,
        input  frame_start, frame_done, frame_error, error_code
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd_out, len_out, payload_data, payload_valid,
        output frame_start, frame_done, frame_error, error_code
    );
endinterface

// File: rtl/frame_parser.sv
// rtl/frame_parser.sv - AA 55 CMD LEN_H LEN_L PAYLOAD CHK byte-stream frame parser
module frame_parser #(
    parameter int MAX_PAYLOAD_LEN = 256,
    parameter int TIMEOUT_CLKS    = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    frame_parser_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHK
    } state_t;

    localparam int              TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [16:0]     MAX_LEN = 17'(MAX_PAYLOAD_LEN);

    state_t        state, state_nx;
    logic [7:0]    acc, acc_nx;
    logic [15:0]   cnt, cnt_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [7:0]    cmd_q, cmd_nx;
    logic [15:0]   len_q, len_nx;
    logic [7:0]    pdata_q, pdata_nx;
    logic          pvalid_q, pvalid_nx;
    logic          start_q, start_nx;
    logic          done_q, done_nx;
    logic          err_q, err_nx;
    logic [1:0]    code_q, code_nx;
    logic [15:0]   full_len;
    logic          active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            tcnt     <= tcnt_nx;
            cmd_q    <= cmd_nx;
            len_q    <= len_nx;
            pdata_q  <= pdata_nx;
            pvalid_q <= pvalid_nx;
            start_q  <= start_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
            code_q   <= code_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        tcnt_nx   = tcnt;
        cmd_nx    = cmd_q;
        len_nx    = len_q;
        pdata_nx  = pdata_q;
        pvalid_nx = 1'b0;
        start_nx  = 1'b0;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        code_nx   = code_q;
        full_len  = {len_q[15:8], bus.rx_data};
        active    = (state != S_IDLE) && (state != S_SYNC);

        if (bus.rx_valid) begin
            // A byte always wins over a timeout expiring in the same cycle.
            tcnt_nx = '0;
            case (state)
                S_IDLE: if (bus.rx_data == 8'hAA) state_nx = S_SYNC;
                S_SYNC: begin
                    if (bus.rx_data == 8'h55)      state_nx = S_CMD;
                    else if (bus.rx_data != 8'hAA) state_nx = S_IDLE;
                end
                S_CMD: begin
                    cmd_nx   = bus.rx_data;
                    acc_nx   = bus.rx_data;
                    start_nx = 1'b1;
                    state_nx = S_LEN_H;
                end
                S_LEN_H: begin
                    len_nx[15:8] = bus.rx_data;
                    acc_nx       = acc + bus.rx_data;
                    state_nx     = S_LEN_L;
                end
                S_LEN_L: begin
                    len_nx[7:0] = bus.rx_data;
                    acc_nx      = acc + bus.rx_data;
                    if ({1'b0, full_len} > MAX_LEN) begin
                        err_nx   = 1'b1;
                        code_nx  = 2'b10;
                        state_nx = S_IDLE;
                    end else if (full_len == 16'd0) begin
                        state_nx = S_CHK;
                    end else begin
                        cnt_nx   = full_len;
                        state_nx = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    pdata_nx  = bus.rx_data;
                    pvalid_nx = 1'b1;
                    acc_nx    = acc + bus.rx_data;
                    cnt_nx    = cnt - 16'd1;
                    if (cnt == 16'd1) state_nx = S_CHK;
                end
                S_CHK: begin
                    if (bus.rx_data == acc) begin
                        done_nx = 1'b1;
                    end else begin
                        err_nx  = 1'b1;
                        code_nx = 2'b01;
                    end
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (active) begin
            if (tcnt == T_LAST) begin
                err_nx   = 1'b1;
                code_nx  = 2'b11;
                tcnt_nx  = '0;
                state_nx = S_IDLE;
            end else begin
                tcnt_nx = tcnt + 1'b1;
            end
        end
    end

    assign bus.cmd_out       = cmd_q;
    assign bus.len_out       = len_q;
    assign bus.payload_data  = pdata_q;
    assign bus.payload_valid = pvalid_q;
    assign bus.frame_start   = start_q;
    assign bus.frame_done    = done_q;
    assign bus.frame_error   = err_q;
    assign bus.error_code    = code_q;
endmodule

// File: tb/tb_frame_parser.sv
// tb/tb_frame_parser.sv - self-checking bench for frame_parser against a frame-level model
module tb_frame_parser;
    localparam int MAXL = 256;
    localparam int TO   = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frame_parser_if bus ();
    frame_parser #(.MAX_PAYLOAD_LEN(MAXL), .TIMEOUT_CLKS(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // model state: hunting for AA 55, or collecting the bytes after it
    bit          m_open, m_have_aa;
    logic [7:0]  fbuf[$];
    int          m_gap;
    logic [7:0]  m_cmd;
    logic [15:0] m_len;
    logic [1:0]  m_code;
    bit          e_start, e_pv, e_done, e_err;
    logic [7:0]  e_pdata;

    int          n_done, n_err, n_start;
    logic [7:0]  got_pl[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_open = 0; m_have_aa = 0; fbuf.delete(); m_gap = 0;
        m_cmd = '0; m_len = '0; m_code = '0;
        e_start = 0; e_pv = 0; e_done = 0; e_err = 0; e_pdata = '0;
    endfunction

    function automatic void model_step(bit v, logic [7:0] b);
        int n, s;
        e_start = 0; e_pv = 0; e_done = 0; e_err = 0;
        if (v) begin
            m_gap = 0;
            if (!m_open) begin
                if (m_have_aa && b == 8'h55) begin
                    m_open = 1; m_have_aa = 0; fbuf.delete();
                end else begin
                    m_have_aa = (b == 8'hAA);
                end
            end else begin
                fbuf.push_back(b);
                n = fbuf.size();
                if (n == 1) begin
                    e_start = 1; m_cmd = b;
                end else if (n == 2) begin
                    m_len[15:8] = b;
                end else if (n == 3) begin
                    m_len[7:0] = b;
                    if (int'(m_len) > MAXL) begin
                        e_err = 1; m_code = 2'b10; m_open = 0;
                    end
                end else if (n == 4 + int'(m_len)) begin
                    s = 0;
                    for (int i = 0; i < n - 1; i++) s += int'(fbuf[i]);
                    if ((s & 255) == int'(b)) e_done = 1;
                    else begin e_err = 1; m_code = 2'b01; end
                    m_open = 0;
                end else begin
                    e_pv = 1; e_pdata = b;
                end
            end
        end else if (m_open) begin
            m_gap++;
            if (m_gap == TO) begin
                e_err = 1; m_code = 2'b11; m_open = 0; m_gap = 0;
            end
        end
    endfunction

    always @(posedge clk) begin
        #1;
        chk("frame_start", 32'(bus.frame_start), 32'(e_start));
        chk("payload_valid", 32'(bus.payload_valid), 32'(e_pv));
        chk("frame_done", 32'(bus.frame_done), 32'(e_done));
        chk("frame_error", 32'(bus.frame_error), 32'(e_err));
        chk("error_code", 32'(bus.error_code), 32'(m_code));
        chk("cmd_out", 32'(bus.cmd_out), 32'(m_cmd));
        chk("len_out", 32'(bus.len_out), 32'(m_len));
        if (e_pv) chk("payload_data", 32'(bus.payload_data), 32'(e_pdata));
        if (bus.payload_valid) got_pl.push_back(bus.payload_data);
        if (bus.frame_done)  n_done++;
        if (bus.frame_error) n_err++;
        if (bus.frame_start) n_start++;
    end

    task automatic cyc(input bit v, input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_data  = v ? b : 8'h00;
        model_step(v, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] q[$], input int gap);
        foreach (q[i]) begin
            cyc(1'b1, q[i]);
            idle(gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        @(posedge clk); #1;
        chk("reset_payload_data", 32'(bus.payload_data), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_counts();
        n_done = 0; n_err = 0; n_start = 0; got_pl.delete();
    endtask

    logic [7:0] f1[$], f2[$], f3[$], f4[$], f5[$], stray[$], big[$];

    initial begin
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        f1    = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
        f2    = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h3D};
        f3    = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h3C};
        f4    = '{8'hAA, 8'h55, 8'h02, 8'h01, 8'h01, 8'h04};
        f5    = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h04, 8'hDE};
        stray = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
        big   = '{8'hAA, 8'h55, 8'h03, 8'h01, 8'h00};
        for (int i = 0; i < 256; i++) big.push_back(8'(i));
        big.push_back(8'h84);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();

        send(f1, 1); idle(3);
        chk("t1_done_count", 32'(n_done), 1);
        chk("t1_start_count", 32'(n_start), 1);
        chk("t1_cmd", 32'(bus.cmd_out), 32'hFF);
        chk("t1_len", 32'(bus.len_out), 32'h0);
        chk("t1_no_payload", 32'(got_pl.size()), 0);

        clear_counts();
        send(f2, 1); idle(3);
        chk("t2_payload_count", 32'(got_pl.size()), 4);
        if (got_pl.size() == 4) begin
            chk("t2_pl0", 32'(got_pl[0]), 32'hDE);
            chk("t2_pl1", 32'(got_pl[1]), 32'hAD);
            chk("t2_pl2", 32'(got_pl[2]), 32'hBE);
            chk("t2_pl3", 32'(got_pl[3]), 32'hEF);
        end
        chk("t2_done_count", 32'(n_done), 1);

        clear_counts();
        send(f3, 0); idle(3);
        chk("t3_payload_count", 32'(got_pl.size()), 4);
        chk("t3_err_count", 32'(n_err), 1);
        chk("t3_done_count", 32'(n_done), 0);
        chk("t3_code", 32'(bus.error_code), 32'h1);

        clear_counts();
        send(f4, 1); idle(3);
        chk("t4_err_count", 32'(n_err), 1);
        chk("t4_code", 32'(bus.error_code), 32'h2);
        chk("t4_len", 32'(bus.len_out), 32'h0101);
        send(f1, 0); idle(3);
        chk("t4_recover_done", 32'(n_done), 1);

        clear_counts();
        send(f5, 1); idle(TO + 5);
        chk("t5_err_count", 32'(n_err), 1);
        chk("t5_code", 32'(bus.error_code), 32'h3);
        send(stray, 1); idle(3);
        chk("t5_resync_done", 32'(n_done), 1);

        clear_counts();
        send(f1, TO - 1); idle(3);
        chk("gap_edge_done", 32'(n_done), 1);
        chk("gap_edge_err", 32'(n_err), 0);

        clear_counts();
        send(big, 0); idle(3);
        chk("maxlen_done", 32'(n_done), 1);
        chk("maxlen_payload", 32'(got_pl.size()), 256);

        clear_counts();
        cyc(1'b1, 8'hAA); idle(TO + 10); cyc(1'b1, 8'h55);
        send(f1[2:5], 0); idle(3);
        chk("sync_no_timeout", 32'(n_err), 0);
        chk("sync_wait_done", 32'(n_done), 1);

        clear_counts();
        send(f2[0:6], 1);
        do_reset();
        idle(2);
        chk("t6_reset_done", 32'(n_done), 0);
        chk("t6_reset_err", 32'(n_err), 0);
        chk("t6_reset_cmd", 32'(bus.cmd_out), 32'h0);
        chk("t6_reset_len", 32'(bus.len_out), 32'h0);
        send(f1, 1); idle(2);
        send(f2, 0); idle(3);
        chk("t6_after_reset_done", 32'(n_done), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
